// File: rtl/instr_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes, the bundle type,
// immediate range checking and standard bit placement for each format.
package instr_enc_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    // An immediate fits when every bit above the encodable field is a copy of its sign bit.
    function automatic logic imm_err(input logic [2:0] fmt, input logic [31:0] imm);
        logic err;
        err = 1'b1;
        case (fmt)
            FMT_R:        err = 1'b0;
            FMT_I, FMT_S: err = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            FMT_J:        err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            FMT_U:        err = |imm[11:0];
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] pack(input fields_t f);
        logic [31:0] w;
        w = NOP_INSTR;
        case (f.fmt)
            FMT_R: w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I: w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_S: w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            FMT_B: w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                        f.imm[4:1], f.imm[11], f.opcode};
            FMT_U: w = {f.imm[31:12], f.rd, f.opcode};
            FMT_J: w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            default: w = NOP_INSTR;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Two-stage streaming RV32I encoder: S1 captures the bundle and its range-check result,
// S2 packs the word, tags it with its IMEM byte address and holds it until accepted.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    input  logic                 load_base,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    fields_t             in_fields;
    fields_t             s1_fields;
    logic                s1_valid;
    logic                s1_err;
    logic                s2_ready;
    logic                s1_advance;
    logic [ADDR_W-1:0]   addr_cnt;

    assign in_fields = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                         rs2: in_rs2, funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    // Ready ripples back from out_ready only; in_valid never feeds in_ready.
    assign s2_ready   = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_ready;
    assign in_ready   = !s1_valid || s1_advance;

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_err    <= 1'b0;
            s1_fields <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fields <= in_fields;
                s1_err    <= imm_err(in_fmt, in_imm);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            out_err   <= 1'b0;
            err_count <= '0;
            addr_cnt  <= '0;
        end else begin
            if (s2_ready) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_instr <= s1_err ? NOP_INSTR : pack(s1_fields);
                    out_err   <= s1_err;
                    out_addr  <= addr_cnt;
                    if (s1_err && !(&err_count))
                        err_count <= err_count + ERR_CNT_W'(1);
                end
            end
            // A coincident S2 load still takes the old count; the base applies to the next word.
            if (load_base)
                addr_cnt <= base_addr & ~ADDR_W'(3);
            else if (s1_advance)
                addr_cnt <= addr_cnt + ADDR_W'(4);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;
    import instr_enc_pkg::*;

    localparam int ADDR_W    = 12;
    localparam int ERR_CNT_W = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_fmt;
    logic [6:0]           in_opcode;
    logic [4:0]           in_rd;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [2:0]           in_funct3;
    logic [6:0]           in_funct7;
    logic [31:0]          in_imm;
    logic                 load_base;
    logic [ADDR_W-1:0]    base_addr;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_instr;
    logic [ADDR_W-1:0]    out_addr;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } word_t;

    word_t got_q[$];

    instr_encoder #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .load_base(load_base), .base_addr(base_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Words transfer at the posedge following a negedge where valid && ready hold.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready)
            got_q.push_back('{instr: out_instr, addr: out_addr, err: out_err});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic push(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        int n;
        n = 0;
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("push_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 50) begin
            @(negedge clk);
            k++;
        end
        #3;
        check("drain_count", 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] instr,
                               input logic [ADDR_W-1:0] addr, input logic err);
        word_t w;
        if (got_q.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            w = got_q.pop_front();
            check({tag, "_instr"}, w.instr, instr);
            check({tag, "_addr"}, 32'(w.addr), 32'(addr));
            check({tag, "_err"}, 32'(w.err), 32'(err));
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; load_base = 1'b0; base_addr = '0;
        in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // I-type, latency of two edges from handshake to out_valid
        push(FMT_I, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF);
        check("lat_after_s1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_after_s2", 32'(out_valid), 32'd1);
        wait_words(1);
        expect_word("i_neg1", 32'hFFF1_0093, 12'h000, 1'b0);

        // S then B back to back
        @(negedge clk);
        push(FMT_S, 7'b0100011, 5'd0, 5'd2, 5'd1, 3'b010, 7'd0, 32'd8);
        push(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd16);
        wait_words(2);
        expect_word("s_imm8", 32'h0011_2423, 12'h004, 1'b0);
        expect_word("b_imm16", 32'h0020_8863, 12'h008, 1'b0);

        // U then J
        @(negedge clk);
        push(FMT_U, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0001_2000);
        push(FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048);
        wait_words(2);
        expect_word("u_upper", 32'h0001_20B7, 12'h00C, 1'b0);
        expect_word("j_2048", 32'h0010_00EF, 12'h010, 1'b0);

        // Errors substitute a NOP, count, and still consume an address
        @(negedge clk);
        push(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd17);
        wait_words(1);
        expect_word("err_b_odd", NOP_INSTR, 12'h014, 1'b1);
        check("err_count_1", 32'(err_count), 32'd1);
        @(negedge clk);
        push(FMT_I, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd2048);
        wait_words(1);
        expect_word("err_i_range", NOP_INSTR, 12'h018, 1'b1);
        check("err_count_2", 32'(err_count), 32'd2);
        @(negedge clk);
        push(3'd7, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd0);
        wait_words(1);
        expect_word("err_fmt7", NOP_INSTR, 12'h01C, 1'b1);
        check("err_count_3", 32'(err_count), 32'd3);

        // Most negative legal I immediate
        @(negedge clk);
        push(FMT_I, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'hFFFF_F800);
        wait_words(1);
        expect_word("i_min", 32'h8001_0093, 12'h020, 1'b0);
        check("err_count_hold", 32'(err_count), 32'd3);

        // Asynchronous reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        push(FMT_I, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd1);
        push(FMT_I, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd2);
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        check("mid_rst_out_addr", 32'(out_addr), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        @(negedge clk);

        // Backpressure: two absorbed, output held, then drained in order
        push(FMT_I, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF);
        push(FMT_S, 7'b0100011, 5'd0, 5'd2, 5'd1, 3'b010, 7'd0, 32'd8);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_instr", out_instr, 32'hFFF1_0093);
            check("bp_hold_addr", 32'(out_addr), 32'd0);
        end
        @(negedge clk);
        fork
            push(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd16);
            begin
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_words(3);
        expect_word("bp_w0", 32'hFFF1_0093, 12'h000, 1'b0);
        expect_word("bp_w1", 32'h0011_2423, 12'h004, 1'b0);
        expect_word("bp_w2", 32'h0020_8863, 12'h008, 1'b0);

        // load_base coinciding with word 1 entering S2
        @(negedge clk);
        push(FMT_U, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0001_2000);
        load_base = 1'b1;
        base_addr = 12'h103;
        @(negedge clk);
        load_base = 1'b0;
        push(FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048);
        wait_words(2);
        expect_word("lb_w1_old", 32'h0001_20B7, 12'h00C, 1'b0);
        expect_word("lb_w2_base", 32'h0010_00EF, 12'h100, 1'b0);

        // R-type with base-relative address continuing
        @(negedge clk);
        push(FMT_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'b0100000, 32'hDEAD_BEEF);
        wait_words(1);
        expect_word("r_sub", 32'h4020_81B3, 12'h104, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder: the inverse of the immediate generator in the decode path.
- Takes a field bundle (format, opcode, register indices, funct fields, full 32-bit immediate) and packs it into a legal 32-bit instruction word.
- Range-checks the immediate and tags each word with its instruction-memory byte address.
- Sits between the bench/boot program loader and the IMEM write port; valid/ready on both sides.

Parameters:
- ADDR_W, 12, width of the IMEM byte-address counter.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_fmt  in  3  instruction format code (package constants)
- in_opcode  in  7  opcode[6:0]
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_imm  in  32  immediate as a signed byte value; for U format, the full upper value
- load_base  in  1  load address counter
- base_addr  in  ADDR_W  new start address; bits [1:0] ignored
- out_valid  out  1  encoded word valid
- out_ready  in  1  IMEM side accepts the word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_instr
- out_err  out  1  this word is a substituted NOP due to an error
- err_count  out  ERR_CNT_W  saturating count of errored words

Behaviour:
- Reset (async, rst_n=0): all stage valids 0, out_valid=0, out_instr=0, out_addr=0, out_err=0, err_count=0, address counter=0.
- Pipeline has two registered stages.
  - S1 (check): captures the bundle on in_valid&&in_ready and evaluates the error flag.
  - S2 (pack/output): drives out_* directly from flops.
  - Latency: 2 cycles from input handshake to out_valid with out_ready=1.
  - Throughput: 1 word/cycle.
- Handshake rules:
  - Each stage advances when its downstream is empty or is accepting.
  - in_ready = !s1_valid || s1_advance, so 2 bundles are absorbed under stall.
  - out_* are held stable while out_valid && !out_ready.
  - in_ready has no combinational path from in_valid.
- Packing (standard RV32I bit placement):
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Error conditions:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]!=0.
  - R: never.
  - Undefined fmt: always.
- On error: out_instr=32'h00000013 (addi x0,x0,0), out_err=1, err_count+1. err_count saturates at all-ones.
- Address assignment:
  - out_addr is assigned to a word when it enters S2.
  - The counter increments by 4 on each S2 load and wraps modulo 2^ADDR_W.
- load_base:
  - Counter becomes {base_addr[ADDR_W-1:2],2'b00}.
  - If an S2 load coincides, that word takes the old counter value. The next word gets the base.
  - A word already held in S2 keeps its address.
- Errored words consume an address.

Decomposition:
- Package instr_enc_pkg holds:
  - FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5 (6,7 undefined).
  - NOP_INSTR=32'h00000013.
  - Range-check and pack functions.
- No sub-module; S1/S2 are in-line registers.

Test Plan:
- I, opcode 0010011, rd=1, rs1=2, f3=0, imm=32'hFFFFFFFF -> out_instr=32'hFFF10093, out_addr=0, out_err=0, 2 cycles after handshake.
- S: rs2=1, rs1=2, f3=010, imm=8 (opcode 0100011) -> 32'h00112423. B: rs1=1, rs2=2, f3=0, imm=16 (opcode 1100011) -> 32'h00208863. Consecutive words; addresses 0 and 4.
- U: rd=1, opcode 0110111, imm=32'h00012000 -> 32'h000120B7. J: rd=1, opcode 1101111, imm=2048 -> 32'h001000EF.
- Errors:
  - B with imm=17 -> 32'h00000013, out_err=1, err_count=1.
  - I with imm=2048 -> NOP, err_count=2.
  - fmt=7 -> NOP, err_count=3.
  - Each consumes an address.
- Backpressure and load_base:
  - out_ready=0 for 4 cycles while 3 bundles are offered -> in_ready drops after 2 accepted; outputs held stable; then words emerge in order at 0,4,8.
  - load_base=1, base_addr=12'h103, asserted in the cycle word 1 enters S2 -> word 1 keeps its old address, word 2 at 12'h100.
- Reset mid-stream: assert rst_n=0 with both stages full -> out_valid=0, err_count=0, counter=0 immediately (async). First post-reset word at address 0.
